if_stage_buf: RTL and testbench
===============================

# if_stage_buf

Parametrised instruction-fetch stage for the LoongArch pipeline. It drives an sram-like instruction port with split address/data handshakes and up to IBUF_DEPTH requests in flight. Returned instructions go into an instruction buffer feeding decode. It handles branch redirects and exception flushes by discarding stale responses, and raises the ADEF (misaligned fetch) flag itself. It replaces the single-entry, always-ready fetch stage between the PC generator and decode.

## Interface
- RESET_PC, 32'h1c000000, first fetch address after reset
- IBUF_DEPTH, 4, instruction buffer entries and maximum outstanding requests; power of two, ≥2
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- ds_allowin  in  1  decode accepts the head entry this cycle
- fs_to_ds_valid  out  1  head entry valid
- fs_to_ds_bus  out  65  {adef, pc[31:0], inst[31:0]} of head entry
- br_taken  in  1  branch redirect request
- br_target  in  32  branch target
- flush  in  1  exception/ertn flush
- flush_target  in  32  flush entry PC
- inst_sram_req  out  1  request valid
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'd2
- inst_sram_wstrb  out  4  constant 4'b0
- inst_sram_addr  out  32  fetch PC
- inst_sram_wdata  out  32  constant 0
- inst_sram_addr_ok  in  1  request accepted this cycle
- inst_sram_data_ok  in  1  response valid this cycle; responses return in request order
- inst_sram_rdata  in  32  response data

## Operation
- State:
  - fetch_pc (reset RESET_PC)
  - pending-PC FIFO: PCs of accepted requests, depth IBUF_DEPTH
  - inflight count, 0..IBUF_DEPTH
  - discard count
  - ibuf FIFO with count
  - halt flag (reset 0)
- Occupancy = inflight + ibuf count; it never exceeds IBUF_DEPTH. Stale in-flight requests still count toward occupancy.
- inst_sram_req = resetn && !halt && !redirect && fetch_pc[1:0]==0 && occupancy<IBUF_DEPTH. Here redirect = flush | br_taken.
- inst_sram_addr = fetch_pc.
- Request accept (req && addr_ok):
  - push fetch_pc into the pending FIFO
  - inflight +1
  - fetch_pc += 4, with 32-bit wrap: 0xFFFFFFFC becomes 0x00000000
- Response (data_ok):
  - pop the pending FIFO; inflight −1
  - if discard>0: discard −1, drop the data
  - else: push {0, pc, rdata} into ibuf
- Simultaneous accept and response in the same cycle: inflight is unchanged.
- Redirect:
  - flush has priority over br_taken.
  - fetch_pc <= flush ? flush_target : br_target
  - ibuf cleared; any pop that cycle is ignored
  - halt <= 0
  - discard <= inflight − data_ok, i.e. every request still outstanding at the end of the cycle
  - No request is issued in the redirect cycle.
- ADEF: when fetch_pc[1:0]≠0, !halt and occupancy<IBUF_DEPTH:
  - push {1, fetch_pc, 32'h0} into ibuf
  - set halt
  - Fetching stays stopped until the next redirect.
  - The ADEF entry goes into a different ibuf slot than any same-cycle response push; ibuf accepts up to two pushes per cycle, in order response then ADEF. Occupancy guarantees room for both.
- Output: fs_to_ds_valid = ibuf count≠0. The head pops when ds_allowin && fs_to_ds_valid && !redirect.
- Reset (async, any time): all counts, pointers and halt are cleared; fetch_pc = RESET_PC. A response arriving for a request from before reset is the environment's responsibility; the bus is reset together with this block.

## Timing
- Outputs during reset: inst_sram_req=0, fs_to_ds_valid=0, inst_sram_addr=RESET_PC.
- First request: the first rising edge after resetn deasserts sees req=1 with addr RESET_PC.
- ibuf is registered:
  - response at cycle M → fs_to_ds_valid at M+1 at the earliest
  - ADEF detected at cycle N → valid at N+1
- Throughput: one request per cycle while occupancy<IBUF_DEPTH and addr_ok=1. Sustained rate is one instruction per cycle once the pipeline is filled.
- Full: occupancy==IBUF_DEPTH → req=0. A pop in the same cycle does not re-enable req until the next cycle, because occupancy uses registered counts.
- Empty: fs_to_ds_valid=0. ds_allowin has no effect.
- Redirect while discard>0 from an earlier redirect: discard is recomputed as above. The result is correct because all inflight requests are stale.

## Test plan
- Reset release, addr_ok and data_ok always 1 with one-cycle latency → addresses 0x1c000000, 0x1c000004, 0x1c000008… in consecutive cycles; decode receives matching pc/inst in order, one per cycle.
- ds_allowin=0 for 10 cycles → exactly IBUF_DEPTH requests accepted and req drops; raising ds_allowin drains entries in order with no loss or duplication.
- Three requests in flight, br_taken with target 0x1c000100 → the three stale responses are dropped, ibuf is cleared, and the next request address is 0x1c000100 in the cycle after the redirect.
- flush with flush_target 0x1c008000 and br_taken in the same cycle → fetch resumes at 0x1c008000.
- br_target 0x1c000102 → no bus request; decode receives adef=1, pc=0x1c000102; fetching stays halted until a flush to 0x1c008000 resumes it.
- Random addr_ok/data_ok stalls plus random redirects against a reference model → every instruction delivered to decode matches the model's PC stream.

Source files
------------

// File: rtl/if_stage_buf_if.sv
// Handshake bundle between the fetch stage, the instruction sram port and decode.
// master = fetch stage side, slave = memory/decode/redirect environment.
interface if_stage_buf_if;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        br_taken;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_target;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin, br_taken, br_target, flush, flush_target,
           inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_wr,
           inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_taken, br_target, flush, flush_target,
           inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_wr,
           inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_stage_buf.sv
// Instruction-fetch stage: issues in-order sram fetches, tracks the PCs in flight,
// buffers returned instructions for decode and drops responses made stale by redirects.
module if_stage_buf #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic           clk,
  input  logic           resetn,
  if_stage_buf_if.master bus
);
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [31:0]   fetch_pc;
  logic          halt;
  logic [31:0]   pend_mem [IBUF_DEPTH];
  logic [PW-1:0] pend_wptr;
  logic [PW-1:0] pend_rptr;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [64:0]   ibuf_mem [IBUF_DEPTH];
  logic [PW-1:0] ib_wptr;
  logic [PW-1:0] ib_rptr;
  logic [CW-1:0] ib_count;

  logic [OW-1:0] occupancy;
  logic          has_room;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          accept;
  logic          resp;
  logic          resp_push;
  logic          adef_push;
  logic          pop;
  logic [PW-1:0] adef_slot;

  // Stale requests still occupy a slot, so a full buffer can always absorb every response.
  assign occupancy   = OW'(inflight) + OW'(ib_count);
  assign has_room    = occupancy < OW'(IBUF_DEPTH);
  assign redirect    = bus.flush | bus.br_taken;
  assign redirect_pc = bus.flush ? bus.flush_target : bus.br_target;

  assign bus.inst_sram_req   = resetn && !halt && !redirect &&
                               (fetch_pc[1:0] == 2'b00) && has_room;
  assign bus.inst_sram_addr  = fetch_pc;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = 2'd2;
  assign bus.inst_sram_wstrb = 4'b0000;
  assign bus.inst_sram_wdata = 32'h0;

  assign accept    = bus.inst_sram_req && bus.inst_sram_addr_ok;
  assign resp      = bus.inst_sram_data_ok;
  assign resp_push = resp && (discard == '0) && !redirect;
  assign adef_push = (fetch_pc[1:0] != 2'b00) && !halt && has_room && !redirect;
  assign pop       = bus.ds_allowin && bus.fs_to_ds_valid && !redirect;
  // A same-cycle response takes the first free slot; the ADEF record goes behind it.
  assign adef_slot = ib_wptr + PW'(resp_push);

  assign bus.fs_to_ds_valid = (ib_count != '0);
  assign bus.fs_to_ds_bus   = ibuf_mem[ib_rptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc  <= RESET_PC;
      halt      <= 1'b0;
      pend_wptr <= '0;
      pend_rptr <= '0;
      inflight  <= '0;
      discard   <= '0;
      ib_wptr   <= '0;
      ib_rptr   <= '0;
      ib_count  <= '0;
    end else begin
      if (accept) pend_wptr <= pend_wptr + 1'b1;
      if (resp)   pend_rptr <= pend_rptr + 1'b1;
      inflight <= inflight + CW'(accept) - CW'(resp);
      if (redirect) begin
        // Everything still outstanding after this cycle belongs to the old path.
        fetch_pc <= redirect_pc;
        halt     <= 1'b0;
        discard  <= inflight - CW'(resp);
        ib_wptr  <= '0;
        ib_rptr  <= '0;
        ib_count <= '0;
      end else begin
        if (accept)                      fetch_pc <= fetch_pc + 32'd4;
        if (adef_push)                   halt     <= 1'b1;
        if (resp && (discard != '0))     discard  <= discard - 1'b1;
        if (pop)                         ib_rptr  <= ib_rptr + 1'b1;
        ib_wptr  <= ib_wptr + PW'(resp_push) + PW'(adef_push);
        ib_count <= ib_count + CW'(resp_push) + CW'(adef_push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)    pend_mem[pend_wptr] <= fetch_pc;
    if (resp_push) ibuf_mem[ib_wptr]   <= {1'b0, pend_mem[pend_rptr], bus.inst_sram_rdata};
    if (adef_push) ibuf_mem[adef_slot] <= {1'b1, fetch_pc, 32'h0};
  end
endmodule

// File: tb/tb_if_stage_buf.sv
// Bench for if_stage_buf: a fixed vector table from reset, hand-built redirect/ADEF/wrap
// sequences, then random bus stalls and redirects against a queue-based fetch model.
module tb_if_stage_buf;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam int          D      = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  if_stage_buf_if bus();
  if_stage_buf #(.RESET_PC(RST_PC), .IBUF_DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  // Reference model: expected decode queue, requests in flight tagged stale/live.
  logic [31:0] m_pc;
  bit          m_halt;
  logic [64:0] m_ib[$];
  logic [31:0] m_infl_pc[$];
  bit          m_infl_stale[$];
  logic [31:0] mem_q[$];
  bit          dok_en;

  task automatic drive(input bit ds, input bit aok, input bit br, input logic [31:0] brt,
                       input bit fl, input logic [31:0] flt);
    bus.ds_allowin        = ds;
    bus.inst_sram_addr_ok = aok;
    bus.br_taken          = br;
    bus.br_target         = brt;
    bus.flush             = fl;
    bus.flush_target      = flt;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    dok_en                = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = 32'h0;
    resetn = 1'b0;
    #1;
    chk("rst.req", 65'(bus.inst_sram_req), 65'(0));
    chk("rst.vld", 65'(bus.fs_to_ds_valid), 65'(0));
    chk("rst.addr", 65'(bus.inst_sram_addr), 65'(RST_PC));
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req2", 65'(bus.inst_sram_req), 65'(0));
    m_pc = RST_PC;
    m_halt = 1'b0;
    m_ib.delete();
    m_infl_pc.delete();
    m_infl_stale.delete();
    mem_q.delete();
    resetn = 1'b1;
  endtask

  // One clock: environment answers, outputs compared with the model, model advanced.
  task automatic step(input string tag);
    bit redirect, room, mreq, accept, pop, adef, aligned;
    int occ;
    bus.inst_sram_data_ok = dok_en && (mem_q.size() != 0);
    bus.inst_sram_rdata   = (mem_q.size() != 0) ? inst_of(mem_q[0]) : 32'h0;
    #1;
    occ      = m_infl_pc.size() + m_ib.size();
    redirect = bus.flush || bus.br_taken;
    aligned  = (m_pc[1:0] == 2'b00);
    room     = occ < D;
    mreq     = !m_halt && !redirect && aligned && room;
    chk({tag, ".req"}, 65'(bus.inst_sram_req), 65'(mreq));
    chk({tag, ".addr"}, 65'(bus.inst_sram_addr), 65'(m_pc));
    chk({tag, ".vld"}, 65'(bus.fs_to_ds_valid), 65'(m_ib.size() != 0));
    if (m_ib.size() != 0) chk({tag, ".bus"}, bus.fs_to_ds_bus, m_ib[0]);

    accept = mreq && bus.inst_sram_addr_ok;
    pop    = bus.ds_allowin && (m_ib.size() != 0) && !redirect;
    adef   = !aligned && !m_halt && room && !redirect;
    if (pop) void'(m_ib.pop_front());
    if (bus.inst_sram_data_ok && (m_infl_pc.size() != 0)) begin
      logic [31:0] rpc;
      bit          st;
      rpc = m_infl_pc.pop_front();
      st  = m_infl_stale.pop_front();
      if (!st && !redirect) m_ib.push_back({1'b0, rpc, inst_of(rpc)});
    end
    if (adef) begin
      m_ib.push_back({1'b1, m_pc, 32'h0});
      m_halt = 1'b1;
    end
    if (accept) begin
      m_infl_pc.push_back(m_pc);
      m_infl_stale.push_back(1'b0);
      m_pc = m_pc + 32'd4;
    end
    if (redirect) begin
      m_ib.delete();
      foreach (m_infl_stale[i]) m_infl_stale[i] = 1'b1;
      m_pc   = bus.flush ? bus.flush_target : bus.br_target;
      m_halt = 1'b0;
    end
    if (bus.inst_sram_data_ok && (mem_q.size() != 0)) void'(mem_q.pop_front());
    if (bus.inst_sram_req && bus.inst_sram_addr_ok) mem_q.push_back(bus.inst_sram_addr);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          ds, aok, dok, br;
    logic [31:0] rd_pc, brt;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_vld;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mk(input bit ds, input bit aok, input bit dok, input logic [31:0] rd_off,
                              input bit br, input bit e_req, input logic [31:0] e_off,
                              input bit e_vld, input logic [31:0] e_pc_off);
    vec_t v;
    v.ds = ds; v.aok = aok; v.dok = dok; v.br = br;
    v.rd_pc = RST_PC + rd_off;
    v.brt = RST_PC + 32'h100;
    v.e_req = e_req; v.e_addr = RST_PC + e_off;
    v.e_vld = e_vld; v.e_pc = RST_PC + e_pc_off;
    return v;
  endfunction

  function automatic logic [31:0] rnd_target();
    logic [31:0] t;
    int r;
    t = RST_PC + (32'($urandom_range(0, 63)) << 2);
    r = $urandom_range(0, 15);
    if (r == 0)      t = t + 32'd2;
    else if (r == 1) t = 32'hFFFFFFF0 + (32'($urandom_range(0, 3)) << 2);
    return t;
  endfunction

  initial begin
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = 32'h0;
    #2;
    do_reset();

    //          ds aok dok rd     br  req addr   vld pc
    tbl[0]  = mk(1, 1, 0, 32'h0,  0,  1, 32'h0,   0, 32'h0);
    tbl[1]  = mk(1, 1, 1, 32'h0,  0,  1, 32'h4,   0, 32'h0);
    tbl[2]  = mk(1, 1, 1, 32'h4,  0,  1, 32'h8,   1, 32'h0);
    tbl[3]  = mk(1, 1, 1, 32'h8,  0,  1, 32'hC,   1, 32'h4);
    tbl[4]  = mk(0, 1, 1, 32'hC,  0,  1, 32'h10,  1, 32'h8);
    tbl[5]  = mk(0, 1, 1, 32'h10, 0,  1, 32'h14,  1, 32'h8);
    tbl[6]  = mk(0, 1, 1, 32'h14, 0,  0, 32'h18,  1, 32'h8);
    tbl[7]  = mk(0, 1, 0, 32'h0,  0,  0, 32'h18,  1, 32'h8);
    tbl[8]  = mk(1, 1, 0, 32'h0,  0,  0, 32'h18,  1, 32'h8);
    tbl[9]  = mk(0, 1, 0, 32'h0,  0,  1, 32'h18,  1, 32'hC);
    tbl[10] = mk(0, 1, 0, 32'h0,  0,  0, 32'h1C,  1, 32'hC);
    tbl[11] = mk(1, 1, 0, 32'h0,  1,  0, 32'h1C,  1, 32'hC);
    tbl[12] = mk(1, 1, 1, 32'h18, 0,  1, 32'h100, 0, 32'h0);
    tbl[13] = mk(1, 1, 1, 32'h100,0,  1, 32'h104, 0, 32'h0);
    tbl[14] = mk(1, 1, 1, 32'h104,0,  1, 32'h108, 1, 32'h100);
    tbl[15] = mk(1, 0, 0, 32'h0,  0,  1, 32'h10C, 1, 32'h104);
    tbl[16] = mk(1, 0, 1, 32'h108,0,  1, 32'h10C, 0, 32'h0);
    tbl[17] = mk(1, 0, 0, 32'h0,  0,  1, 32'h10C, 1, 32'h108);
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ds, tbl[i].aok, tbl[i].br, tbl[i].brt, 1'b0, 32'h0);
      bus.inst_sram_data_ok = tbl[i].dok;
      bus.inst_sram_rdata   = tbl[i].dok ? inst_of(tbl[i].rd_pc) : 32'h0;
      #1;
      chk($sformatf("vec%0d.req", i), 65'(bus.inst_sram_req), 65'(tbl[i].e_req));
      chk($sformatf("vec%0d.addr", i), 65'(bus.inst_sram_addr), 65'(tbl[i].e_addr));
      chk($sformatf("vec%0d.vld", i), 65'(bus.fs_to_ds_valid), 65'(tbl[i].e_vld));
      if (tbl[i].e_vld)
        chk($sformatf("vec%0d.bus", i), bus.fs_to_ds_bus,
            {1'b0, tbl[i].e_pc, inst_of(tbl[i].e_pc)});
      @(posedge clk);
      #1;
    end
    chk("const.wr", 65'(bus.inst_sram_wr), 65'(0));
    chk("const.size", 65'(bus.inst_sram_size), 65'(2));
    chk("const.wstrb", 65'(bus.inst_sram_wstrb), 65'(0));
    chk("const.wdata", 65'(bus.inst_sram_wdata), 65'(0));

    // Three requests in flight, then a branch: stale data dropped, new path next cycle.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) step("stale.fill");
    drive(1'b1, 1'b1, 1'b1, RST_PC + 32'h100, 1'b0, 32'h0);
    step("stale.br");
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    dok_en = 1'b1;
    #1;
    chk("stale.addr", 65'(bus.inst_sram_addr), 65'(RST_PC + 32'h100));
    chk("stale.req", 65'(bus.inst_sram_req), 65'(1));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stale.empty%0d", k), 65'(bus.fs_to_ds_valid), 65'(0));
      step("stale.drain");
    end
    #1;
    chk("stale.first", bus.fs_to_ds_bus, {1'b0, RST_PC + 32'h100, inst_of(RST_PC + 32'h100)});
    repeat (6) step("stale.run");

    // flush beats br_taken in the same cycle.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    dok_en = 1'b1;
    step("prio.pre");
    drive(1'b1, 1'b1, 1'b1, RST_PC + 32'h200, 1'b1, 32'h1c008000);
    step("prio.redir");
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("prio.addr", 65'(bus.inst_sram_addr), 65'(32'h1c008000));
    chk("prio.req", 65'(bus.inst_sram_req), 65'(1));
    repeat (5) step("prio.run");

    // Misaligned branch target: ADEF record, halt, then flush resumes fetch.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    dok_en = 1'b1;
    step("adef.pre");
    drive(1'b0, 1'b1, 1'b1, RST_PC + 32'h102, 1'b0, 32'h0);
    step("adef.br");
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("adef.noreq", 65'(bus.inst_sram_req), 65'(0));
    step("adef.detect");
    #1;
    chk("adef.vld", 65'(bus.fs_to_ds_valid), 65'(1));
    chk("adef.bus", bus.fs_to_ds_bus, {1'b1, RST_PC + 32'h102, 32'h0});
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("adef.halt%0d", k), 65'(bus.inst_sram_req), 65'(0));
      step("adef.halted");
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1c008000);
    step("adef.flush");
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("adef.resume.req", 65'(bus.inst_sram_req), 65'(1));
    chk("adef.resume.addr", 65'(bus.inst_sram_addr), 65'(32'h1c008000));
    repeat (5) step("adef.run");

    // Fetch PC wraps from 0xFFFFFFFC to 0.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFF8, 1'b0, 32'h0);
    dok_en = 1'b1;
    step("wrap.br");
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) step("wrap.run");
    #1;
    chk("wrap.addr", 65'(bus.inst_sram_addr), 65'(0));
    repeat (6) step("wrap.tail");

    // Random stalls and redirects.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit br, fl;
      br = ($urandom_range(0, 19) == 0);
      fl = ($urandom_range(0, 31) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, br, rnd_target(),
            fl, rnd_target());
      dok_en = $urandom_range(0, 9) < 7;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
